// File: rtl/input_mux_pkg.sv
// Shared helpers for the quad-tree operand reorder pipeline: log2 sizing,
// grid element indexing and the source-index maps used to wire each stage.
package input_mux_pkg;

  // Ceiling log2 for elaboration-time sizing; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Row-major element index of (r,c) in a grid of side n.
  function automatic int idx(input int r, input int c, input int n);
    return c + n * r;
  endfunction

  // Source element feeding output element p after the level-k quad split of
  // a grid of side n. The vector is viewed as 4^k row-major sub-blocks of
  // side s = n >> k; each sub-block is rewritten as {q3,q2,q1,q0}, with every
  // quadrant itself flattened row-major with side s/2. Only valid for s >= 2.
  function automatic int level_src(input int p, input int n, input int k);
    int s;
    int h;
    int blk_sz;
    int q_sz;
    int blk;
    int off;
    int q;
    int qoff;
    int row;
    int col;
    s      = n >> k;
    h      = s / 2;
    blk_sz = s * s;
    q_sz   = h * h;
    blk    = p / blk_sz;
    off    = p % blk_sz;
    q      = off / q_sz;
    qoff   = off % q_sz;
    row    = (q / 2) * h + qoff / h;
    col    = (q % 2) * h + qoff % h;
    return blk * blk_sz + idx(row, col, s);
  endfunction

  // Source element feeding output element p when the grid is transposed.
  function automatic int transpose_src(input int p, input int n);
    return idx(p % n, p / n, n);
  endfunction

endpackage

// File: rtl/input_mux_stage.sv
// One pipeline slice of the operand reorder: an elastic register with
// valid/ready that applies its recursion level when the held beat's mode
// asks for it, and optionally transposes the grid first (stage 0 only).
module input_mux_stage
  import input_mux_pkg::*;
#(
  parameter int N            = 4,
  parameter int L_PRECISION  = 4,
  parameter int LEVEL        = 0,
  parameter int TRANSPOSE_EN = 0,
  parameter int MODE_W       = 2,
  parameter int DATA_WIDTH   = N * N * L_PRECISION
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MODE_W-1:0]     in_mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MODE_W-1:0]     out_mode,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DATA_WIDTH-1:0] base_data;
  logic [DATA_WIDTH-1:0] perm_data;
  logic [DATA_WIDTH-1:0] next_data;

  // The slice can take a beat when empty or when its own beat leaves now.
  assign in_ready = !out_valid || out_ready;

  // Transpose happens only for split beats; mode 0 must stay a pure delay.
  if (TRANSPOSE_EN != 0) begin : g_trans
    logic [DATA_WIDTH-1:0] trans_data;
    for (genvar p = 0; p < N * N; p++) begin : g_elem
      localparam int TSRC = transpose_src(p, N);
      assign trans_data[p*L_PRECISION +: L_PRECISION] = in_data[TSRC*L_PRECISION +: L_PRECISION];
    end
    assign base_data = (in_mode != '0) ? trans_data : in_data;
  end else begin : g_no_trans
    assign base_data = in_data;
  end

  // Fixed wiring for this stage's level; a 1x1 grid has nothing to split.
  if (N > 1) begin : g_perm
    for (genvar p = 0; p < N * N; p++) begin : g_elem
      localparam int SRC = level_src(p, N, LEVEL);
      assign perm_data[p*L_PRECISION +: L_PRECISION] = base_data[SRC*L_PRECISION +: L_PRECISION];
    end
  end else begin : g_identity
    assign perm_data = base_data;
  end

  // Apply this level only when the beat requests more levels than this index.
  always_comb begin
    next_data = in_data;
    if (int'(in_mode) > LEVEL) next_data = perm_data;
  end

  // Register slice: data and mode load with the beat and hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_mode  <= '0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_mode <= in_mode;
        out_data <= next_data;
      end
    end
  end

endmodule

// File: rtl/input_mux_pipe.sv
// Pipelined quad-tree operand reorder for the spatial multiplier: one split
// level per stage, per-beat mode, full-throughput valid/ready handshake.
module input_mux_pipe
  import input_mux_pkg::*;
#(
  parameter int PRECISION   = 8,
  parameter int L_PRECISION = 2,
  parameter int TRANSPOSE   = 0,
  parameter int N           = PRECISION / L_PRECISION,
  parameter int DATA_WIDTH  = N * PRECISION,
  parameter int LEVELS      = clog2(N),
  parameter int STAGES      = (LEVELS > 1) ? LEVELS : 1,
  parameter int MODE_W      = (clog2(LEVELS + 1) > 1) ? clog2(LEVELS + 1) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MODE_W-1:0]     in_mode,
  input  logic [DATA_WIDTH-1:0] a_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] a_out
);

  localparam logic [MODE_W-1:0] MAX_MODE = MODE_W'(LEVELS);

  logic                  vld_pipe  [STAGES+1];
  logic                  rdy_pipe  [STAGES+1];
  logic [MODE_W-1:0]     mode_pipe [STAGES+1];
  logic [DATA_WIDTH-1:0] data_pipe [STAGES+1];
  logic [MODE_W-1:0]     sat_mode;

  // Requests for more levels than exist are clamped to a full split.
  always_comb begin
    sat_mode = in_mode;
    if (in_mode > MAX_MODE) sat_mode = MAX_MODE;
  end

  assign vld_pipe[0]      = in_valid;
  assign mode_pipe[0]     = sat_mode;
  assign data_pipe[0]     = a_in;
  assign rdy_pipe[STAGES] = out_ready;

  // Inputs offered while in reset are refused so no beat survives reset.
  assign in_ready  = rdy_pipe[0] && !reset;
  assign out_valid = vld_pipe[STAGES];
  assign a_out     = data_pipe[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    input_mux_stage #(
      .N            (N),
      .L_PRECISION  (L_PRECISION),
      .LEVEL        (k),
      .TRANSPOSE_EN ((k == 0) ? TRANSPOSE : 0),
      .MODE_W       (MODE_W),
      .DATA_WIDTH   (DATA_WIDTH)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (vld_pipe[k]),
      .in_ready  (rdy_pipe[k]),
      .in_mode   (mode_pipe[k]),
      .in_data   (data_pipe[k]),
      .out_valid (vld_pipe[k+1]),
      .out_ready (rdy_pipe[k+1]),
      .out_mode  (mode_pipe[k+1]),
      .out_data  (data_pipe[k+1])
    );
  end

endmodule

// File: tb/tb_input_mux_pipe.sv
// Directed self-checking bench for input_mux_pipe with a 4x4 grid of 4-bit
// elements; an A-side (no transpose) and a B-side (transpose) copy share inputs.
module tb_input_mux_pipe;

  localparam logic [63:0] VEC_A  = 64'hFEDCBA9876543210;
  localparam logic [63:0] VEC_C  = 64'h0123456789ABCDEF;
  localparam logic [63:0] EXP_A2 = 64'hFEBADC9876325410;
  localparam logic [63:0] EXP_T2 = 64'hFBEA7362D9C85140;

  localparam int MAP_A [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
  localparam int MAP_T [16] = '{0, 4, 1, 5, 8, 12, 9, 13, 2, 6, 3, 7, 10, 14, 11, 15};

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_mode;
  logic [63:0] a_in;
  logic        out_ready;
  logic        in_ready0;
  logic        in_ready1;
  logic        out_valid0;
  logic        out_valid1;
  logic [63:0] a_out0;
  logic [63:0] a_out1;

  int total;
  int bad;
  int sent;
  int recv;
  int cyc;
  logic [1:0]  beat_mode;
  logic [63:0] beat_data;
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];

  input_mux_pipe #(.PRECISION(16), .L_PRECISION(4), .TRANSPOSE(0)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .in_mode   (in_mode),
    .a_in      (a_in),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .a_out     (a_out0)
  );

  input_mux_pipe #(.PRECISION(16), .L_PRECISION(4), .TRANSPOSE(1)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_mode   (in_mode),
    .a_in      (a_in),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .a_out     (a_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference reorder from hand-derived 4x4 maps; mode 0 is a pure delay.
  function automatic logic [63:0] expected(input logic [1:0] mode, input logic [63:0] d, input bit tr);
    logic [63:0] r;
    int src;
    r = d;
    if (mode != 2'd0) begin
      for (int p = 0; p < 16; p++) begin
        src = tr ? MAP_T[p] : MAP_A[p];
        r[p*4 +: 4] = d[src*4 +: 4];
      end
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [63:0] d, input logic ordy);
    in_valid  = v;
    in_mode   = m;
    a_in      = d;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic directedBeat(input string tag, input logic [1:0] mode, input logic [63:0] exp0, input logic [63:0] exp1);
    applyStimulus(1'b1, mode, VEC_A, 1'b1);
    #1;
    checkOutput({tag, "_in_ready"}, 64'(in_ready0), 64'd1);
    tick();
    applyStimulus(1'b0, 2'd0, 64'd0, 1'b1);
    #1;
    checkOutput({tag, "_early"}, 64'(out_valid0), 64'd0);
    tick();
    checkOutput({tag, "_valid_a"}, 64'(out_valid0), 64'd1);
    checkOutput({tag, "_data_a"}, a_out0, exp0);
    checkOutput({tag, "_valid_b"}, 64'(out_valid1), 64'd1);
    checkOutput({tag, "_data_b"}, a_out1, exp1);
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    applyStimulus(1'b0, 2'd0, 64'd0, 1'b1);
    tick();
    tick();
    checkOutput("rst_valid", 64'(out_valid0), 64'd0);
    checkOutput("rst_data_a", a_out0, 64'd0);
    checkOutput("rst_data_b", a_out1, 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready0), 64'd0);
    reset = 1'b0;
    tick();

    directedBeat("mode2", 2'd2, EXP_A2, EXP_T2);
    directedBeat("mode1", 2'd1, EXP_A2, EXP_T2);
    directedBeat("mode0", 2'd0, VEC_A, VEC_A);
    directedBeat("mode3_sat", 2'd3, EXP_A2, EXP_T2);

    // Fill the pipe while stalled, then let exactly one beat through.
    applyStimulus(1'b1, 2'd0, VEC_A, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd2, VEC_A, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd1, VEC_C, 1'b0);
    #1;
    checkOutput("full_in_ready", 64'(in_ready0), 64'd0);
    checkOutput("full_valid", 64'(out_valid0), 64'd1);
    checkOutput("full_data", a_out0, VEC_A);
    tick();
    checkOutput("stall_data", a_out0, VEC_A);
    checkOutput("stall_in_ready", 64'(in_ready0), 64'd0);
    applyStimulus(1'b1, 2'd1, VEC_C, 1'b1);
    #1;
    checkOutput("pass_in_ready", 64'(in_ready0), 64'd1);
    tick();
    applyStimulus(1'b0, 2'd0, VEC_A, 1'b0);
    #1;
    checkOutput("one_valid", 64'(out_valid0), 64'd1);
    checkOutput("one_data", a_out0, EXP_A2);
    checkOutput("one_in_ready", 64'(in_ready0), 64'd0);
    applyStimulus(1'b0, 2'd0, VEC_A, 1'b1);
    tick();
    checkOutput("third_valid", 64'(out_valid0), 64'd1);
    checkOutput("third_data_a", a_out0, expected(2'd1, VEC_C, 1'b0));
    checkOutput("third_data_b", a_out1, expected(2'd1, VEC_C, 1'b1));
    tick();
    checkOutput("drained", 64'(out_valid0), 64'd0);

    // Reset with two beats in flight must discard both.
    applyStimulus(1'b1, 2'd2, VEC_A, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd0, VEC_C, 1'b0);
    tick();
    reset = 1'b1;
    applyStimulus(1'b1, 2'd2, VEC_A, 1'b1);
    #1;
    checkOutput("midrst_in_ready", 64'(in_ready0), 64'd0);
    tick();
    checkOutput("midrst_valid", 64'(out_valid0), 64'd0);
    checkOutput("midrst_data_a", a_out0, 64'd0);
    checkOutput("midrst_data_b", a_out1, 64'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 2'd0, VEC_A, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("postrst_valid", 64'(out_valid0), 64'd0);
    end

    // Back-to-back beats with alternating mode and random backpressure.
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 16 && cyc < 400) begin
      beat_mode = (sent % 2 == 1) ? 2'd2 : 2'd0;
      beat_data = {$urandom, $urandom};
      applyStimulus(sent < 16, beat_mode, beat_data, 1'($urandom_range(0, 1)));
      #1;
      if (out_valid0) begin
        if (q0.size() == 0) begin
          checkOutput("stream_extra", 64'(out_valid0), 64'd0);
        end else begin
          checkOutput("stream_a", a_out0, q0[0]);
          checkOutput("stream_b", a_out1, q1[0]);
          if (out_ready) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
            recv++;
          end
        end
      end
      if (in_valid && in_ready0) begin
        q0.push_back(expected(beat_mode, beat_data, 1'b0));
        q1.push_back(expected(beat_mode, beat_data, 1'b1));
        sent++;
      end
      tick();
      cyc++;
    end
    checkOutput("stream_count", 64'(recv), 64'd16);
    checkOutput("stream_left", 64'(q0.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
